// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO read-side round-robin arbiter.
//   arb_state_e : arbiter FSM states
//   next_idx    : modulo-n increment, explicit compare so non-power-of-two n wraps correctly
//   cnt_width   : width of a counter that must hold 0..max inclusive
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    function automatic int next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Finds the first asserted request at or after ptr, wrapping at N_SRC.
//   req   in  N_SRC          request vector
//   ptr   in  $clog2(N_SRC)  search start index (must be < N_SRC)
//   found out 1              at least one request asserted
//   idx   out $clog2(N_SRC)  index of the chosen request (0 when none)
module rr_pick #(
    parameter int  N_SRC = 4,
    localparam int IDX_W = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // One spare bit so ptr + offset cannot overflow before the wrap compare.
    logic [IDX_W:0] pos;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            pos = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (pos >= (IDX_W + 1)'(N_SRC)) begin
                pos = pos - (IDX_W + 1)'(N_SRC);
            end
            if (req[pos[IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: drains N_SRC source FIFOs into one registered output stream,
// round-robin, holding each source for up to BURST_LEN consecutive beats.
//   clk, rst_n   clock, asynchronous active-low reset
//   src_valid_i  per-source FIFO has data
//   src_data_i   per-source FIFO pop data (unpacked array)
//   src_grant_o  per-source pop grant, at most one bit high
//   out_valid_o  output register holds a word
//   out_data_o   output word
//   out_src_o    source index of out_data_o
//   out_grant_i  consumer accepts the word
// Build option: define FIFO_ARB_LAST_EN to treat data bit DATA_WIDTH as a
// "last" marker that ends the current burst early.
//
// state | meaning
// IDLE  | no owner; every cycle is an arbitration from rr_ptr
// BURST | cur owns the stream; beat_cnt beats taken so far
module fifo_rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int  N_SRC      = 4,
    parameter int  DATA_WIDTH = 32,
    parameter int  BURST_LEN  = 4,
    localparam int IDX_W      = $clog2(N_SRC)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_SRC-1:0]      src_valid_i,
    input  logic [DATA_WIDTH:0]   src_data_i [N_SRC],
    output logic [N_SRC-1:0]      src_grant_o,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH:0]   out_data_o,
    output logic [IDX_W-1:0]      out_src_o,
    input  logic                  out_grant_i
);

    localparam int CNT_W = cnt_width(BURST_LEN);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] cur_q, cur_d;
    logic [CNT_W-1:0] beat_q, beat_d;

    logic             accept;
    logic             owner_live;
    logic [IDX_W-1:0] search_ptr;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] sel;
    logic             xfer;
    logic [CNT_W-1:0] cnt_next;
    logic             last_mark;
    logic             burst_end;

    assign accept     = !out_valid_o || out_grant_i;
    assign owner_live = (state_q == BURST) && src_valid_i[cur_q];

    // A dropped owner moves the search start past itself in the same cycle,
    // giving it the lowest priority in this arbitration.
    assign search_ptr = (state_q == BURST) ? IDX_W'(next_idx(int'(cur_q), N_SRC)) : rr_ptr_q;

    rr_pick #(.N_SRC(N_SRC)) u_pick (
        .req   (src_valid_i),
        .ptr   (search_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign sel      = owner_live ? cur_q : pick_idx;
    assign xfer     = accept && (owner_live || pick_found);
    assign cnt_next = owner_live ? beat_q + CNT_W'(1) : CNT_W'(1);

`ifdef FIFO_ARB_LAST_EN
    assign last_mark = src_data_i[sel][DATA_WIDTH];
`else
    assign last_mark = 1'b0;
`endif

    assign burst_end = (cnt_next == CNT_W'(BURST_LEN)) || last_mark;

    // Grant is combinational; gated by rst_n so no pop happens while held in reset.
    always_comb begin
        src_grant_o = '0;
        if (rst_n && xfer) begin
            src_grant_o[sel] = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        cur_d    = cur_q;
        beat_d   = beat_q;
        if (accept) begin
            if (!owner_live) begin
                rr_ptr_d = search_ptr;
            end
            if (xfer) begin
                cur_d = sel;
                if (burst_end) begin
                    state_d  = IDLE;
                    rr_ptr_d = IDX_W'(next_idx(int'(sel), N_SRC));
                    beat_d   = '0;
                end else begin
                    state_d = BURST;
                    beat_d  = cnt_next;
                end
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            cur_q    <= '0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cur_q    <= cur_d;
            beat_q   <= beat_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_src_o   <= '0;
        end else if (accept) begin
            out_valid_o <= xfer;
            if (xfer) begin
                out_data_o <= src_data_i[sel];
                out_src_o  <= sel;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Testbench for fifo_rr_arbiter: two instances (4 sources / burst 4, and
// 3 sources / burst 1), behavioural source FIFOs, and a scoreboard monitor.
module tb_fifo_rr_arbiter;

    localparam int AN  = 4;
    localparam int BN  = 3;
    localparam int DW  = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [AN-1:0] a_src_valid, a_src_grant;
    logic [DW:0]   a_src_data [AN];
    logic          a_out_valid, a_out_grant;
    logic [DW:0]   a_out_data;
    logic [1:0]    a_out_src;

    logic [BN-1:0] b_src_valid, b_src_grant;
    logic [DW:0]   b_src_data [BN];
    logic          b_out_valid, b_out_grant;
    logic [DW:0]   b_out_data;
    logic [1:0]    b_out_src;

    fifo_rr_arbiter #(.N_SRC(AN), .DATA_WIDTH(DW), .BURST_LEN(4)) u_dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .src_valid_i (a_src_valid),
        .src_data_i  (a_src_data),
        .src_grant_o (a_src_grant),
        .out_valid_o (a_out_valid),
        .out_data_o  (a_out_data),
        .out_src_o   (a_out_src),
        .out_grant_i (a_out_grant)
    );

    fifo_rr_arbiter #(.N_SRC(BN), .DATA_WIDTH(DW), .BURST_LEN(1)) u_dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .src_valid_i (b_src_valid),
        .src_data_i  (b_src_data),
        .src_grant_o (b_src_grant),
        .out_valid_o (b_out_valid),
        .out_data_o  (b_out_data),
        .out_src_o   (b_out_src),
        .out_grant_i (b_out_grant)
    );

    // Word k of source s: {last flag, s, k}.
    function automatic logic [DW:0] mkword(input int s, input int seq, input int lseq);
        logic [DW:0] w;
        w = {(seq == lseq), s[15:0], seq[15:0]};
        return w;
    endfunction

    // Source FIFO model: pushed is written by the stimulus, popped by the pop model.
    int pushed   [AN] = '{default: 0};
    int popped   [AN] = '{default: 0};
    int last_seq [AN] = '{default: -1};
    int exp_seq  [AN] = '{default: 0};
    logic [BN-1:0] b_valid;

    always_comb begin
        for (int s = 0; s < AN; s++) begin
            a_src_valid[s] = pushed[s] > popped[s];
            a_src_data[s]  = mkword(s, popped[s], last_seq[s]);
        end
        for (int s = 0; s < BN; s++) begin
            b_src_data[s] = mkword(s, 0, -1);
        end
        b_src_valid = b_valid;
    end

    always @(posedge clk) begin
        for (int s = 0; s < AN; s++) begin
            if (rst_n && a_src_grant[s] && a_src_valid[s]) popped[s] <= popped[s] + 1;
        end
    end

    typedef struct {
        int          src;
        logic [DW:0] data;
    } exp_t;

    typedef struct {
        string       name;
        logic [63:0] act;
        logic [63:0] want;
    } chk_t;

    exp_t a_exp[$];
    exp_t b_exp[$];
    chk_t chk_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Monitor: sole owner of the counters; pops the scoreboards on each
    // output handshake and evaluates queued point checks.
    initial begin : monitor
        exp_t e;
        chk_t c;
        forever begin
            @(negedge clk);
            if (a_out_valid && a_out_grant) begin
                n_cmp++;
                if (a_exp.size() == 0) begin
                    n_bad++;
                    $display("FAIL a_word: got src %0d data %0h, want no word", a_out_src, a_out_data);
                end else begin
                    e = a_exp.pop_front();
                    if (int'(a_out_src) != e.src || a_out_data != e.data) begin
                        n_bad++;
                        $display("FAIL a_word: got src %0d data %0h, want src %0d data %0h",
                                 a_out_src, a_out_data, e.src, e.data);
                    end
                end
            end
            if (b_out_valid && b_out_grant) begin
                n_cmp++;
                if (b_exp.size() == 0) begin
                    n_bad++;
                    $display("FAIL b_word: got src %0d data %0h, want no word", b_out_src, b_out_data);
                end else begin
                    e = b_exp.pop_front();
                    if (int'(b_out_src) != e.src || b_out_data != e.data) begin
                        n_bad++;
                        $display("FAIL b_word: got src %0d data %0h, want src %0d data %0h",
                                 b_out_src, b_out_data, e.src, e.data);
                    end
                end
            end
            n_cmp++;
            if (!$onehot0({a_src_grant, 1'b0}) || !$onehot0(b_src_grant)) begin
                n_bad++;
                $display("FAIL grant_onehot: got a %b b %b, want at most one bit each", a_src_grant, b_src_grant);
            end
            while (chk_q.size() != 0) begin
                c = chk_q.pop_front();
                n_cmp++;
                if (c.act != c.want) begin
                    n_bad++;
                    $display("FAIL %s: got %0h, want %0h", c.name, c.act, c.want);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        chk_q.push_back('{name, act, want});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic add(input int s, input int n);
        pushed[s] = pushed[s] + n;
    endtask

    task automatic exp_a(input int s);
        a_exp.push_back('{s, mkword(s, exp_seq[s], last_seq[s])});
        exp_seq[s] = exp_seq[s] + 1;
    endtask

    initial begin : stimulus
        int cnt;
        logic [DW:0] w0;
        rst_n       = 1'b0;
        a_out_grant = 1'b0;
        b_out_grant = 1'b1;
        b_valid     = '0;

        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_out_data",  64'(a_out_data),  64'd0);
        check("rst_out_src",   64'(a_out_src),   64'd0);
        check("rst_grant",     64'(a_src_grant), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Non-power-of-two wrap, BURST_LEN=1: 0,1,2,0,1,2.
        b_valid = 3'b111;
        for (int i = 0; i < 6; i++) b_exp.push_back('{i % 3, mkword(i % 3, 0, -1)});
        tick(6);
        b_valid = '0;
        repeat (2) @(negedge clk);
        check("t4_drained", 64'(b_out_valid), 64'd0);
        check("t4_sb_left", 64'(b_exp.size()), 64'd0);
        tick(1);

        // All four sources valid, full throughput.
        a_out_grant = 1'b1;
        add(0, 5); add(1, 4); add(2, 4); add(3, 4);
        for (int s = 0; s < 4; s++) for (int k = 0; k < 4; k++) exp_a(s);
        exp_a(0);
        @(negedge clk);
        check("t1_first_grant", 64'(a_src_grant), 64'b0001);
        check("t1_no_early_valid", 64'(a_out_valid), 64'd0);
        cnt = 0;
        repeat (17) begin
            @(negedge clk);
            if (a_out_valid) cnt++;
        end
        check("t1_no_bubbles", 64'(cnt), 64'd17);
        @(negedge clk);
        check("t1_drained", 64'(a_out_valid), 64'd0);
        check("t1_sb_left", 64'(a_exp.size()), 64'd0);
        tick(1);

        // Owner drop: source 2 runs dry, search restarts at 3 so 0 beats 1.
        add(2, 3);
        exp_a(2); exp_a(2); exp_a(2);
        tick(3);
        add(0, 2); add(1, 1);
        exp_a(0); exp_a(0); exp_a(1);
        @(negedge clk);
        check("t2_drop_regrant", 64'(a_src_grant), 64'b0001);
        repeat (4) @(negedge clk);
        check("t2_drained", 64'(a_out_valid), 64'd0);
        check("t2_sb_left", 64'(a_exp.size()), 64'd0);
        tick(1);

        // Backpressure for 5 cycles mid-burst.
        a_out_grant = 1'b0;
        w0 = mkword(3, pushed[3], last_seq[3]);
        add(3, 6);
        exp_a(3); exp_a(3); exp_a(3); exp_a(3);
        exp_a(0); exp_a(0); exp_a(3); exp_a(3);
        @(negedge clk);
        check("t3_first_grant", 64'(a_src_grant), 64'b1000);
        tick(1);
        add(0, 2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_stall_grant", 64'(a_src_grant), 64'd0);
            check("t3_stall_data",  64'(a_out_data),  64'(w0));
            check("t3_stall_valid", 64'(a_out_valid), 64'd1);
        end
        tick(1);
        a_out_grant = 1'b1;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (a_out_valid) cnt++;
        end
        check("t3_resume_rate", 64'(cnt), 64'd8);
        @(negedge clk);
        check("t3_drained", 64'(a_out_valid), 64'd0);
        check("t3_sb_left", 64'(a_exp.size()), 64'd0);
        tick(1);

        // Reset mid-burst with beat_cnt=2 and a word in the output register.
        add(1, 4); add(2, 1);
        exp_a(1);
        tick(2);
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 64'(a_out_valid), 64'd0);
        check("t5_rst_grant", 64'(a_src_grant), 64'd0);
        check("t5_rst_data",  64'(a_out_data),  64'd0);
        check("t5_rst_src",   64'(a_out_src),   64'd0);
        exp_seq[1] = exp_seq[1] + 1;
        add(0, 1);
        @(negedge clk);
        check("t5_grant_in_reset", 64'(a_src_grant), 64'd0);
        tick(1);
        rst_n = 1'b1;
        exp_a(0); exp_a(1); exp_a(1); exp_a(2);
        @(negedge clk);
        check("t5_restart_src0", 64'(a_src_grant), 64'b0001);
        repeat (5) @(negedge clk);
        check("t5_drained", 64'(a_out_valid), 64'd0);
        check("t5_sb_left", 64'(a_exp.size()), 64'd0);
        tick(1);

        // Last marker on beat 2 of source 1.
        last_seq[1] = pushed[1] + 1;
        add(1, 4); add(2, 1);
`ifdef FIFO_ARB_LAST_EN
        exp_a(1); exp_a(1); exp_a(2); exp_a(1); exp_a(1);
`else
        exp_a(1); exp_a(1); exp_a(1); exp_a(1); exp_a(2);
`endif
        repeat (3) @(negedge clk);
`ifdef FIFO_ARB_LAST_EN
        check("t6_grant_after_last", 64'(a_src_grant), 64'b0100);
`else
        check("t6_owner_kept", 64'(a_src_grant), 64'b0010);
`endif
        repeat (4) @(negedge clk);
        check("t6_drained", 64'(a_out_valid), 64'd0);
        check("t6_sb_left", 64'(a_exp.size()), 64'd0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_rr_arbiter.md
Name: fifo_rr_arbiter

Overview:
- Round-robin read scheduler that drains N_SRC source FIFOs into one consumer stream.
- Source side uses the FIFO pop handshake: src_valid_i from each FIFO pop_valid_o, src_grant_o into each FIFO pop_grant_i.
- Holds a source for up to BURST_LEN consecutive beats, then moves on.
- Output is a single registered stage, one-cycle latency, using the same valid/grant handshake. Data buses are DATA_WIDTH+1 bits wide, matching the FIFO data path.

Parameters:
- N_SRC, 4: number of source FIFOs, 2..16.
- DATA_WIDTH, 32: data buses are [DATA_WIDTH:0].
- BURST_LEN, 4: maximum consecutive beats per ownership, >=1.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- src_valid_i  in  N_SRC  per-source FIFO has data (pop_valid_o)
- src_data_i  in  N_SRC x (DATA_WIDTH+1)  per-source FIFO pop data, unpacked array
- src_grant_o  out  N_SRC  per-source pop grant (FIFO pop_grant_i), at most one bit high
- out_valid_o  out  1  output register holds a word
- out_data_o  out  DATA_WIDTH+1  output word
- out_src_o  out  $clog2(N_SRC)  index of the source of out_data_o
- out_grant_i  in  1  consumer accepts the word

Behaviour:
- Reset values, asynchronous: state=IDLE, rr_ptr=0, cur=0, beat_cnt=0, out_valid_o=0, out_data_o=0, out_src_o=0. src_grant_o is 0 while rst_n is low.
- accept = !out_valid_o || out_grant_i. When accept=0, src_grant_o=0 and all state, counters and output hold (stall).
- A transfer occurs when src_valid_i[i] && src_grant_o[i]. On the next edge, out_data_o is loaded with src_data_i[i], out_src_o with i, and out_valid_o is set to 1. Latency is 1 cycle.
- If out_grant_i && out_valid_o and there is no transfer, out_valid_o goes to 0 next cycle.
- Simultaneous drain and load gives full throughput of 1 word/cycle.
- States (enum): IDLE, BURST.
- Arbitration cycle: state=IDLE, or state=BURST with src_valid_i[cur]=0.
  - In an arbitration cycle, sel = first i with src_valid_i[i]=1, searching rr_ptr, rr_ptr+1, ... mod N_SRC.
  - If accept=1 and any source is valid, src_grant_o[sel]=1 in the same cycle (combinational).
  - If no source is valid, go to IDLE with rr_ptr unchanged.
- BURST with src_valid_i[cur]=1: src_grant_o[cur]=accept.
- Beat accounting on each transfer from source s:
  - New ownership: cur<=s, beat_cnt<=1.
  - Continuing ownership: beat_cnt<=beat_cnt+1.
  - Burst ends on the beat that makes the count equal BURST_LEN. On that beat: state<=IDLE, rr_ptr<=(s+1) mod N_SRC, beat_cnt<=0.
  - Otherwise state<=BURST.
- Owner drop: state=BURST with src_valid_i[cur]=0 is an arbitration cycle.
  - rr_ptr<=(cur+1) mod N_SRC is applied to the search in that same cycle, so the dropped owner has the lowest priority.
- BURST_LEN=1 is pure per-beat round-robin; state never leaves IDLE.
- rr_ptr wrap: N_SRC-1 advances to 0. Non-power-of-two N_SRC uses explicit compare, never truncation.
- Reset mid-burst: immediate return to the reset values above. Any word in the output register is discarded.
- Starvation bound: a continuously valid source is granted within (N_SRC-1)*BURST_LEN transfers.

Optional Feature:
- Macro: FIFO_ARB_LAST_EN.
- When defined: bit DATA_WIDTH of the data word is a "last" marker. A transfer with src_data_i[s][DATA_WIDTH]=1 ends the burst like reaching BURST_LEN (state<=IDLE, rr_ptr<=s+1).
  - BURST_LEN still caps the burst length.
- When not defined: bit DATA_WIDTH is ordinary payload and has no effect on arbitration.

Decomposition:
- Package fifo_arb_pkg:
  - arb_state_e enum {IDLE, BURST}.
  - Function next_idx(idx, n) for modulo increment.
  - Localparam helper for counter width $clog2(BURST_LEN+1).
- One combinational sub-module rr_pick (parameter N_SRC).
  - Inputs: req[N_SRC], ptr.
  - Outputs: found, idx (first request at or after ptr).
  - Reused by future push-side schedulers.

Test Plan:
1. All 4 sources valid continuously, BURST_LEN=4, out_grant_i=1 -> out_src_o sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0; no bubbles; first out_valid_o one cycle after the first grant.
2. Only source 2 valid with 3 words, then source 0 becomes valid -> out_src_o 2,2,2; source 2 drops, and the same cycle grants 0; following word comes from source 0; rr_ptr is 3 at that arbitration.
3. Backpressure: out_grant_i=0 for 5 cycles while out_valid_o=1 -> src_grant_o=0, out_data_o stable, beat_cnt unchanged; on release, transfers resume at 1 word/cycle with no word lost or duplicated (scoreboard per source).
4. Wrap and non-power-of-two: N_SRC=3, BURST_LEN=1, all valid -> out_src_o 0,1,2,0,1,2; index 3 is never produced.
5. Assert rst_n low mid-burst (beat_cnt=2, out_valid_o=1) -> out_valid_o=0 and src_grant_o=0 immediately; after release, arbitration restarts from source 0.
6. FIFO_ARB_LAST_EN defined: source 1 sends a word with bit DATA_WIDTH=1 on beat 2 of 4 -> next grant goes to source 2. Same stimulus without the macro -> source 1 keeps ownership for 4 beats.
